// File: rtl/regfile_wport_arbiter.sv
// Write-port arbiter for the 16-entry ARMv4 register file: round-robin between
// ALU and load writeback, diverts R15 writes to a PC strobe, and sweeps R0..R14 to zero on command.
module regfile_wport_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CLEAR_LAST = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  we3,
  output logic [ADDR_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0] wd3,
  output logic                  pc_we,
  output logic [DATA_WIDTH-1:0] pc_wdata
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_last_grant;

  logic                  w_arb_open;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  // A clear command closes arbitration for its own cycle, so it wins over any pending request.
  assign w_arb_open = (r_state == ST_ARB) && !clear_start;
  assign w_grant0   = w_arb_open && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1   = w_arb_open && req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept   = w_grant0 || w_grant1;
  assign w_addr     = w_grant1 ? req1_addr : req0_addr;
  assign w_data     = w_grant1 ? req1_data : req0_data;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign busy       = (r_state == ST_CLEAR);

  // NOTE: every register here is updated with <= so all of them sample the pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ARB;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      we3          <= 1'b0;
      a3           <= '0;
      wd3          <= '0;
      pc_we        <= 1'b0;
      pc_wdata     <= '0;
    end else begin
      we3   <= 1'b0;
      pc_we <= 1'b0;
      if (r_state == ST_CLEAR) begin
        we3   <= 1'b1;
        a3    <= r_cnt;
        wd3   <= '0;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == ADDR_WIDTH'(CLEAR_LAST)) begin
          r_state <= ST_ARB;
        end
      end else if (clear_start) begin
        r_state <= ST_CLEAR;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_last_grant <= w_grant1;
        // The all-ones address is the PC; it never reaches the register array.
        if (w_addr == '1) begin
          pc_we    <= 1'b1;
          pc_wdata <= w_data;
        end else begin
          we3 <= 1'b1;
          a3  <= w_addr;
          wd3 <= w_data;
        end
      end
    end
  end

endmodule
